// File: rtl/mouse_pos_sync_if.sv
// Mouse position bus: raw controller inputs in, conditioned position and button out.
// The master side drives the raw inputs; the slave side is the conditioning stage.
interface mouse_pos_sync_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             left_in;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic             moved;
  logic             left_out;
  logic             left_press;

  modport master (
    output x_in, y_in, left_in,
    input  x_out, y_out, moved, left_out, left_press
  );

  modport slave (
    input  x_in, y_in, left_in,
    output x_out, y_out, moved, left_out, left_press
  );
endinterface

// File: rtl/mouse_pos_sync.sv
// Mouse position conditioning: synchroniser chain, stability filter with clamp,
// and one-cycle strobes for position change and left-button press.
module mouse_pos_sync #(
  parameter int WIDTH         = 12,
  parameter int STAGES        = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int X_MAX         = 799,
  parameter int Y_MAX         = 599
) (
  input  logic              clk,
  input  logic              rst_n,
  mouse_pos_sync_if.slave   bus
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] XM       = WIDTH'(X_MAX);
  localparam logic [WIDTH-1:0] YM       = WIDTH'(Y_MAX);

  logic [SW-1:0]      sync_q [STAGES];
  logic [2*WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic               moved_q, moved_d;
  logic               left_prev_q;
  logic               press_q, press_d;
  logic [2*WIDTH-1:0] s_xy;
  logic               s_left;
  logic [WIDTH-1:0]   x_pub, y_pub;

  assign s_xy   = sync_q[STAGES-1][SW-1:1];
  assign s_left = sync_q[STAGES-1][0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.x_in, bus.y_in, bus.left_in};
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // X and Y qualify together; a saturated count keeps re-publishing the same
  // clamped value, which the output compare turns into a single moved pulse.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    moved_d = 1'b0;
    x_pub   = (cand_q[2*WIDTH-1:WIDTH] > XM) ? XM : cand_q[2*WIDTH-1:WIDTH];
    y_pub   = (cand_q[WIDTH-1:0] > YM) ? YM : cand_q[WIDTH-1:0];
    if (s_xy != cand_q) begin
      cand_d = s_xy;
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else if ({x_pub, y_pub} != {x_q, y_q}) begin
      x_d     = x_pub;
      y_d     = y_pub;
      moved_d = 1'b1;
    end
    press_d = s_left & ~left_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      moved_q     <= 1'b0;
      left_prev_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      moved_q     <= moved_d;
      left_prev_q <= s_left;
      press_q     <= press_d;
    end
  end

  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.moved      = moved_q;
  assign bus.left_out   = s_left;
  assign bus.left_press = press_q;
endmodule

// File: tb/tb_mouse_pos_sync.sv
// Self-checking bench for mouse_pos_sync: directed scenarios plus randomized
// stimulus against a delay-line / run-length reference model.
module tb_mouse_pos_sync;
  localparam int STAGES = 2;
  localparam int SC     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mouse_pos_sync_if #(.WIDTH(12)) bus1 ();
  mouse_pos_sync_if #(.WIDTH(10)) bus2 ();

  mouse_pos_sync #(.WIDTH(12), .STAGES(STAGES), .STABLE_CYCLES(SC),
                   .X_MAX(799), .Y_MAX(599))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus1));

  mouse_pos_sync #(.WIDTH(10), .STAGES(1), .STABLE_CYCLES(1),
                   .X_MAX(1023), .Y_MAX(1023))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Reference model: synchronised word = input delayed by STAGES edges;
  // a value publishes once it has been seen SC+1 times in a row.
  logic [24:0] mq[$];
  logic [24:0] m_s;
  logic [23:0] m_val;
  int          m_run;
  logic [11:0] m_x, m_y;
  logic        m_moved, m_press, m_lprev, m_left;

  function automatic logic [11:0] clampv(logic [11:0] v, int mx);
    return (int'(v) > mx) ? 12'(mx) : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < STAGES - 1; i++) mq.push_back('0);
    m_s = '0; m_val = '0; m_run = 2;
    m_x = '0; m_y = '0; m_moved = 0; m_press = 0; m_lprev = 0; m_left = 0;
  endtask

  task automatic model_step();
    logic [11:0] xp, yp;
    m_moved = 1'b0;
    if (m_run >= SC + 1) begin
      xp = clampv(m_val[23:12], 799);
      yp = clampv(m_val[11:0], 599);
      if ({xp, yp} != {m_x, m_y}) begin
        m_x = xp; m_y = yp; m_moved = 1'b1;
      end
    end
    m_press = m_s[0] & ~m_lprev;
    m_lprev = m_s[0];
    mq.push_back({bus1.x_in, bus1.y_in, bus1.left_in});
    m_s = mq.pop_front();
    if (m_s[24:1] == m_val) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_val = m_s[24:1];
      m_run = 1;
    end
    m_left = m_s[0];
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [11:0] x, input logic [11:0] y, input logic l);
    bus1.x_in = x; bus1.y_in = y; bus1.left_in = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(12'd100, 12'd50, 1'b0);
    bus2.x_in = '0; bus2.y_in = '0; bus2.left_in = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus1.x_out, bus1.y_out, bus1.moved, bus1.left_out, bus1.left_press} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d mv=%b lo=%b lp=%b, want all 0",
               bus1.x_out, bus1.y_out, bus1.moved, bus1.left_out, bus1.left_press);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_checks++;
      if ({bus1.x_out, bus1.y_out, bus1.moved} !== {m_x, m_y, m_moved}) begin
        n_fail++;
        $display("FAIL reset_release_model edge%0d: got x=%0d y=%0d mv=%b, want x=%0d y=%0d mv=%b",
                 e, bus1.x_out, bus1.y_out, bus1.moved, m_x, m_y, m_moved);
      end
      n_checks++;
      if (bus1.moved !== (e == 7)) begin
        n_fail++;
        $display("FAIL reset_release_pulse edge%0d: got moved=%b, want %b", e, bus1.moved, e == 7);
      end
    end
    n_checks++;
    if ({bus1.x_out, bus1.y_out} !== {12'd100, 12'd50}) begin
      n_fail++;
      $display("FAIL reset_release_pos: got (%0d,%0d), want (100,50)", bus1.x_out, bus1.y_out);
    end
  endtask

  task automatic test_glitch();
    drive(12'd300, 12'd200, 1'b0);
    tick(); tick();
    drive(12'd100, 12'd50, 1'b0);
    for (int e = 0; e < 12; e++) begin
      tick();
      n_checks++;
      if ({bus1.x_out, bus1.y_out, bus1.moved} !== {12'd100, 12'd50, 1'b0}) begin
        n_fail++;
        $display("FAIL glitch cycle%0d: got x=%0d y=%0d mv=%b, want x=100 y=50 mv=0",
                 e, bus1.x_out, bus1.y_out, bus1.moved);
      end
    end
  endtask

  task automatic test_clamp();
    int pulses = 0;
    drive(12'd1000, 12'd4095, 1'b0);
    for (int e = 0; e < 12; e++) begin
      tick();
      if (bus1.moved === 1'b1) pulses++;
    end
    n_checks++;
    if ({bus1.x_out, bus1.y_out} !== {12'd799, 12'd599} || pulses != 1) begin
      n_fail++;
      $display("FAIL clamp: got (%0d,%0d) pulses=%0d, want (799,599) pulses=1",
               bus1.x_out, bus1.y_out, pulses);
    end
    pulses = 0;
    drive(12'd900, 12'd4095, 1'b0);
    for (int e = 0; e < 12; e++) begin
      tick();
      if (bus1.moved === 1'b1) pulses++;
    end
    n_checks++;
    if ({bus1.x_out, bus1.y_out} !== {12'd799, 12'd599} || pulses != 0) begin
      n_fail++;
      $display("FAIL clamp_hold: got (%0d,%0d) pulses=%0d, want (799,599) pulses=0",
               bus1.x_out, bus1.y_out, pulses);
    end
  endtask

  task automatic test_button();
    logic [1:0] exp [1:5];
    int pulses = 0;
    exp[1] = 2'b00; exp[2] = 2'b10; exp[3] = 2'b11; exp[4] = 2'b10; exp[5] = 2'b10;
    drive(bus1.x_in, bus1.y_in, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if ({bus1.left_out, bus1.left_press} !== exp[e]) begin
        n_fail++;
        $display("FAIL button edge%0d: got lo=%b lp=%b, want %b", e, bus1.left_out,
                 bus1.left_press, exp[e]);
      end
    end
    drive(bus1.x_in, bus1.y_in, 1'b0);
    for (int e = 0; e < 5; e++) tick();
    drive(bus1.x_in, bus1.y_in, 1'b1);
    for (int e = 0; e < 8; e++) begin
      tick();
      if (bus1.left_press === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1 || bus1.left_out !== 1'b1) begin
      n_fail++;
      $display("FAIL button_repress: got pulses=%0d lo=%b, want pulses=1 lo=1", pulses, bus1.left_out);
    end
  endtask

  task automatic test_random();
    int moves = 0;
    for (int seg = 0; seg < 80; seg++) begin
      int len = $urandom_range(1, 8);
      drive(12'($urandom_range(0, 1100)), 12'($urandom_range(0, 800)), 1'($urandom_range(0, 1)));
      for (int e = 0; e < len; e++) begin
        tick();
        if (m_moved) moves++;
        n_checks++;
        if ({bus1.x_out, bus1.y_out, bus1.moved, bus1.left_out, bus1.left_press} !==
            {m_x, m_y, m_moved, m_left, m_press}) begin
          n_fail++;
          $display("FAIL random seg%0d: got x=%0d y=%0d mv=%b lo=%b lp=%b, want x=%0d y=%0d mv=%b lo=%b lp=%b",
                   seg, bus1.x_out, bus1.y_out, bus1.moved, bus1.left_out, bus1.left_press,
                   m_x, m_y, m_moved, m_left, m_press);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    drive(12'd100, 12'd50, 1'b0);
    for (int e = 0; e < 10; e++) tick();
    drive(12'd200, 12'd300, 1'b0);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus1.x_out, bus1.y_out, bus1.moved, bus1.left_press} !== 26'd0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got x=%0d y=%0d mv=%b lp=%b, want all 0",
               bus1.x_out, bus1.y_out, bus1.moved, bus1.left_press);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (bus1.moved === 1'b1) pulses++;
      n_checks++;
      if ({bus1.x_out, bus1.y_out, bus1.moved} !== {m_x, m_y, m_moved} ||
          bus1.moved !== (e == 7)) begin
        n_fail++;
        $display("FAIL async_reset_requal edge%0d: got x=%0d y=%0d mv=%b, want x=%0d y=%0d mv=%b",
                 e, bus1.x_out, bus1.y_out, bus1.moved, m_x, m_y, m_moved);
      end
    end
    n_checks++;
    if (pulses != 1 || {bus1.x_out, bus1.y_out} !== {12'd200, 12'd300}) begin
      n_fail++;
      $display("FAIL async_reset_final: got (%0d,%0d) pulses=%0d, want (200,300) pulses=1",
               bus1.x_out, bus1.y_out, pulses);
    end
  endtask

  task automatic test_param_sweep();
    rst_n = 1'b0;
    bus2.x_in = '0; bus2.y_in = '0; bus2.left_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    bus2.x_in = 10'd5; bus2.y_in = 10'd7;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (bus2.moved !== (e == 3) ||
          {bus2.x_out, bus2.y_out} !== ((e >= 3) ? {10'd5, 10'd7} : 20'd0)) begin
        n_fail++;
        $display("FAIL param_sweep edge%0d: got x=%0d y=%0d mv=%b, want pos %s mv=%b",
                 e, bus2.x_out, bus2.y_out, bus2.moved, (e >= 3) ? "(5,7)" : "(0,0)", e == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clamp();
    test_button();
    test_random();
    test_async_reset();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mouse_pos_sync.md
# mouse_pos_sync

Parametrised mouse-position conditioning stage between the mouse controller and the drawing/game logic. It registers the X/Y position and the left button through a configurable synchroniser chain. It publishes a new position only after the sampled X/Y word has been stable for a programmable number of cycles, clamped to the visible area. It emits one-cycle strobes on position change and on button press.

## Interface
- WIDTH, 12: bit width of X and Y position buses.
- STAGES, 2: synchroniser flop stages per input bit (>= 1).
- STABLE_CYCLES, 4: consecutive matching cycles required before a position is published (>= 1).
- X_MAX, 799: largest X value passed to output; larger inputs clamp to X_MAX (< 2**WIDTH).
- Y_MAX, 599: largest Y value passed to output; larger inputs clamp to Y_MAX (< 2**WIDTH).

- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- x_in  input  WIDTH  raw mouse X position.
- y_in  input  WIDTH  raw mouse Y position.
- left_in  input  1  raw left-button level.
- x_out  output  WIDTH  published, clamped X position.
- y_out  output  WIDTH  published, clamped Y position.
- moved  output  1  one-cycle pulse when x_out/y_out change.
- left_out  output  1  synchronised left-button level.
- left_press  output  1  one-cycle pulse on left-button rising edge.

## Operation
- Sync chain: {x_in, y_in, left_in} pass through STAGES registers. The last stage is s_xy (2*WIDTH bits) and s_left.
- Stability filter: registers cand (2*WIDTH) and cnt (0..STABLE_CYCLES-1, width $clog2(STABLE_CYCLES)+1).
  - s_xy != cand: cand <= s_xy, cnt <= 0, no publish.
  - s_xy == cand and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s_xy == cand and cnt == STABLE_CYCLES-1: cnt holds (saturates). Publish clamp(cand).
- X and Y are filtered as one word: a change in either restarts the count for both.
- Clamp (unsigned): x_pub = (cand_x > X_MAX) ? X_MAX : cand_x. Same rule for Y with Y_MAX.
- Publish:
  - If {x_pub, y_pub} != {x_out, y_out}: load the outputs and set moved = 1 for exactly that cycle.
  - Otherwise leave the outputs unchanged and keep moved at 0.
  - Saturated cnt therefore never produces repeated pulses.
- Button:
  - left_out = s_left.
  - left_prev <= s_left.
  - left_press <= s_left & ~left_prev (registered).
- moved and left_press are independent and may assert in the same cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - All sync stages, cand, cnt, left_prev cleared to 0.
  - x_out = 0, y_out = 0, moved = 0, left_out = 0, left_press = 0, immediately without waiting for clk.
- Reset release: the first active edge is the first edge with rst_n high. Behaviour is identical to power-up.
- Position latency, for an input held stable from edge 0:
  - s_xy updates at edge STAGES.
  - cand loads at edge STAGES+1.
  - x_out/y_out and the moved pulse appear at edge STAGES+STABLE_CYCLES+1 (defaults: edge 7).
- STABLE_CYCLES = 1: publish at edge STAGES+2.
- Input toggling faster than STABLE_CYCLES cycles: outputs hold their last published value indefinitely.
- Button latency:
  - left_out rises at edge STAGES.
  - left_press is high for the one cycle after edge STAGES+1.
- Reset asserted mid-filter: a pending candidate is discarded and no moved pulse follows release unless re-qualified.
- Position latency after reset release: candidate 0 qualifies but equals x_out/y_out = 0, so there is no pulse.

## Test plan
- Reset with defaults: drive x_in = 100, y_in = 50 with rst_n low -> all outputs 0. Release at edge 0 -> x_out = 100, y_out = 50, moved high for exactly one cycle after edge 7, then low.
- Glitch rejection: stable (100,50) published. Drive (300,200) for 2 cycles, then back to (100,50) -> outputs unchanged, moved never asserts.
- Clamp: x_in = 1000, y_in = 4095 held -> x_out = 799, y_out = 599, one moved pulse. Change to x_in = 900 -> no further moved pulse (clamped value unchanged).
- Button: left_in 0 -> 1 held -> left_out high at edge 2, left_press high one cycle only. Release and re-press -> second single pulse.
- Parameter sweep STAGES = 1, STABLE_CYCLES = 1, WIDTH = 10, X_MAX = Y_MAX = 1023: step input to (5,7) -> published at edge 3.
- Async reset mid-qualification: assert rst_n low between edge 3 and edge 4 of a pending update -> outputs 0 within the same cycle, no moved pulse after release until the input re-qualifies.
